branch_unit: RTL and testbench

Parametrised branch resolution and prediction unit: the successor to the single-cycle branch condition decoder. It holds the architectural flag register and extends the condition set to eight branch types, including negated and overflow conditions. A table of 2-bit saturating counters supplies fetch-stage predictions, and each branch resolved in execute is checked against its prediction. On a mispredict it raises a registered flush pulse train that squashes wrong-path instructions.

---
 rtl/branch_unit.sv | 117 +++++++++++
 tb/tb_branch_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/branch_unit.sv
// Branch resolution and prediction: flag register, eight-way condition decode,
// a table of 2-bit saturating counters, and a mispredict-triggered flush window.
module branch_unit #(
   parameter int PC_WIDTH     = 16,
   parameter int BHT_DEPTH    = 16,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flag_we,
   input  logic                z_in,
   input  logic                n_in,
   input  logic                c_in,
   input  logic                v_in,
   input  logic [PC_WIDTH-1:0] pred_pc,
   output logic                pred_taken,
   input  logic                valid,
   input  logic [3:0]          branch,
   input  logic [PC_WIDTH-1:0] pc,
   input  logic                predicted,
   output logic                jump,
   output logic                mispredict,
   output logic                flush
);

   localparam int         IDX        = $clog2(BHT_DEPTH);
   localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

   function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
      logic [1:0] nxt;
      if (taken) begin
         nxt = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
      end else begin
         nxt = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
      end
      return nxt;
   endfunction

   logic [3:0]                 flags_q, flags_d;
   logic [3:0]                 flush_cnt_q, flush_cnt_d;
   logic                       flush_q;
   logic [BHT_DEPTH-1:0][1:0]  bht_q, bht_d;
   logic                       ev_s, cond_s, jump_s, mispredict_s;
   logic [IDX-1:0]             rd_idx_s, wr_idx_s;
   logic                       unused_s;

   assign rd_idx_s = pred_pc[IDX-1:0];
   assign wr_idx_s = pc[IDX-1:0];
   assign unused_s = ^{pred_pc[PC_WIDTH-1:IDX], pc[PC_WIDTH-1:IDX]};

   // Condition decode and resolution against the registered flags {z,n,c,v}.
   always_comb begin
      cond_s = 1'b0;
      case (branch[2:0])
         3'b000:  cond_s = 1'b1;
         3'b001:  cond_s = flags_q[3];
         3'b010:  cond_s = flags_q[2];
         3'b011:  cond_s = flags_q[1];
         3'b100:  cond_s = flags_q[0];
         3'b101:  cond_s = ~flags_q[3];
         3'b110:  cond_s = ~flags_q[2];
         3'b111:  cond_s = ~flags_q[1];
         default: cond_s = 1'b0;
      endcase
      ev_s         = valid & (flush_cnt_q == 4'd0);
      jump_s       = ev_s & branch[3] & cond_s;
      mispredict_s = ev_s & (jump_s != predicted);
   end

   // Next-state for flags, flush window and the counter table.
   always_comb begin
      flags_d     = flags_q;
      flush_cnt_d = flush_cnt_q;
      bht_d       = bht_q;
      if (flag_we) begin
         flags_d = {z_in, n_in, c_in, v_in};
      end else begin
         flags_d = flags_q;
      end
      if (mispredict_s) begin
         flush_cnt_d = FLUSH_LOAD;
      end else if (flush_cnt_q != 4'd0) begin
         flush_cnt_d = flush_cnt_q - 4'd1;
      end else begin
         flush_cnt_d = flush_cnt_q;
      end
      // Only real, unsquashed branches train the table.
      if (ev_s & branch[3]) begin
         bht_d[wr_idx_s] = sat_update(bht_q[wr_idx_s], jump_s);
      end else begin
         bht_d = bht_q;
      end
   end

   // State registers; counters reset to weakly not-taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_q     <= 4'd0;
         flush_cnt_q <= 4'd0;
         flush_q     <= 1'b0;
         for (int i = 0; i < BHT_DEPTH; i++) begin
            bht_q[i] <= 2'b01;
         end
      end else begin
         flags_q     <= flags_d;
         flush_cnt_q <= flush_cnt_d;
         flush_q     <= (flush_cnt_d != 4'd0);
         bht_q       <= bht_d;
      end
   end

   assign pred_taken = bht_q[rd_idx_s][1];
   assign jump       = jump_s;
   assign mispredict = mispredict_s;
   assign flush      = flush_q;

endmodule

// File: tb/tb_branch_unit.sv
// Directed self-checking bench for branch_unit with hand-computed expectations.
module tb_branch_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flag_we = 1'b0;
   logic        z_in = 1'b0, n_in = 1'b0, c_in = 1'b0, v_in = 1'b0;
   logic [15:0] pred_pc = 16'h0000;
   logic        pred_taken;
   logic        valid = 1'b0;
   logic [3:0]  branch = 4'b0000;
   logic [15:0] pc = 16'h0000;
   logic        predicted = 1'b0;
   logic        jump, mispredict, flush;

   int n_checks = 0;
   int n_pass   = 0;

   branch_unit #(.PC_WIDTH(16), .BHT_DEPTH(16), .FLUSH_CYCLES(2)) dut (
      .clk(clk), .rst_n(rst_n), .flag_we(flag_we),
      .z_in(z_in), .n_in(n_in), .c_in(c_in), .v_in(v_in),
      .pred_pc(pred_pc), .pred_taken(pred_taken),
      .valid(valid), .branch(branch), .pc(pc), .predicted(predicted),
      .jump(jump), .mispredict(mispredict), .flush(flush)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_flags(input logic [3:0] f);
      valid = 1'b0;
      {z_in, n_in, c_in, v_in} = f;
      flag_we = 1'b1;
      tick();
      flag_we = 1'b0;
   endtask

   // Code table: f = {z,n,c,v}
   function automatic logic exp_jump(input logic [3:0] b, input logic [3:0] f);
      case (b)
         4'b1000: return 1'b1;
         4'b1001: return f[3];
         4'b1010: return f[2];
         4'b1011: return f[1];
         4'b1100: return f[0];
         4'b1101: return ~f[3];
         4'b1110: return ~f[2];
         4'b1111: return ~f[1];
         default: return 1'b0;
      endcase
   endfunction

   logic [6:0] tk_v = 7'b0001111;
   logic [6:0] pb_v = 7'b0111110;
   logic [6:0] pa_v = 7'b0011111;
   logic [6:0] ms_v = 7'b0110001;
   logic       e_s;

   initial begin
      // Reset state
      #2;
      check("rst_flush", 32'(flush), 32'd0);
      for (int i = 0; i < 16; i++) begin
         pred_pc = 16'(i);
         #0.2;
         check($sformatf("rst_pred_%0d", i), 32'(pred_taken), 32'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // JZ after reset with clear flags
      valid = 1'b1; branch = 4'b1001; pc = 16'h00A0; predicted = 1'b0;
      #1;
      check("jz_rst_jump", 32'(jump), 32'd0);
      check("jz_rst_misp", 32'(mispredict), 32'd0);
      tick();

      // Flag write is visible only from the next cycle
      flag_we = 1'b1; z_in = 1'b1;
      #1;
      check("jz_same_cyc_jump", 32'(jump), 32'd0);
      check("jz_same_cyc_misp", 32'(mispredict), 32'd0);
      tick();
      flag_we = 1'b0; z_in = 1'b0; predicted = 1'b1;
      #1;
      check("jz_next_jump", 32'(jump), 32'd1);
      check("jz_next_misp", 32'(mispredict), 32'd0);
      branch = 4'b1101; predicted = 1'b0;
      #1;
      check("jnz_next_jump", 32'(jump), 32'd0);
      check("jnz_next_misp", 32'(mispredict), 32'd0);
      tick();

      // Sweep every code against every flag combination
      pc = 16'h00A0;
      for (int f = 0; f < 16; f++) begin
         set_flags(4'(f));
         for (int b = 0; b < 16; b++) begin
            e_s = exp_jump(4'(b), 4'(f));
            branch = 4'(b); predicted = e_s; valid = 1'b1;
            #1;
            check($sformatf("sweep_jump_b%0d_f%0d", b, f), 32'(jump), 32'(e_s));
            check($sformatf("sweep_misp_b%0d_f%0d", b, f), 32'(mispredict), 32'd0);
            tick();
         end
      end

      // Mispredict opens a two-cycle flush window
      set_flags(4'b0010);
      valid = 1'b1; branch = 4'b1011; pc = 16'h0013; predicted = 1'b0;
      #1;
      check("jc_jump", 32'(jump), 32'd1);
      check("jc_misp", 32'(mispredict), 32'd1);
      check("jc_flush_t", 32'(flush), 32'd0);
      tick();
      check("flush_t1", 32'(flush), 32'd1);
      branch = 4'b1000; pc = 16'h0005; predicted = 1'b0;
      #1;
      check("squashed_jump", 32'(jump), 32'd0);
      check("squashed_misp", 32'(mispredict), 32'd0);
      tick();
      valid = 1'b0;
      check("flush_t2", 32'(flush), 32'd1);
      pred_pc = 16'h0005;
      #1;
      check("squashed_no_bht", 32'(pred_taken), 32'd0);
      pred_pc = 16'h0013;
      #1;
      check("jc_trained_idx3", 32'(pred_taken), 32'd1);
      tick();
      check("flush_t3", 32'(flush), 32'd0);

      // Reset in the middle of a flush
      valid = 1'b1; branch = 4'b1011; pc = 16'h0013; predicted = 1'b0;
      #1;
      check("jc2_misp", 32'(mispredict), 32'd1);
      tick();
      valid = 1'b0;
      check("flush_before_rst", 32'(flush), 32'd1);
      rst_n = 1'b0;
      #1;
      check("flush_in_rst", 32'(flush), 32'd0);
      pred_pc = 16'h0013;
      #1;
      check("pred_in_rst", 32'(pred_taken), 32'd0);
      valid = 1'b1; branch = 4'b1000; predicted = 1'b0;
      #1;
      check("jmp_in_rst_jump", 32'(jump), 32'd1);
      check("jmp_in_rst_misp", 32'(mispredict), 32'd1);
      valid = 1'b0;
      rst_n = 1'b1;
      tick();
      check("flush_after_rst", 32'(flush), 32'd0);
      check("pred_after_rst", 32'(pred_taken), 32'd0);
      valid = 1'b1; branch = 4'b1011; pc = 16'h00A0; predicted = 1'b0;
      #1;
      check("flags_cleared_jc", 32'(jump), 32'd0);
      check("flags_cleared_misp", 32'(mispredict), 32'd0);
      tick();
      valid = 1'b0;

      // Train index 3: four taken then three not-taken (z=0 so JZ falls through)
      for (int k = 0; k < 7; k++) begin
         pred_pc = 16'h0003; pc = 16'h0003;
         branch = tk_v[k] ? 4'b1000 : 4'b1001;
         predicted = pb_v[k]; valid = 1'b1;
         #1;
         check($sformatf("train%0d_jump", k), 32'(jump), 32'(tk_v[k]));
         check($sformatf("train%0d_misp", k), 32'(mispredict), 32'(ms_v[k]));
         check($sformatf("train%0d_pred_old", k), 32'(pred_taken), 32'(pb_v[k]));
         tick();
         valid = 1'b0;
         #1;
         check($sformatf("train%0d_pred_new", k), 32'(pred_taken), 32'(pa_v[k]));
         check($sformatf("train%0d_flush", k), 32'(flush), 32'(ms_v[k]));
         tick();
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
